// File: rtl/char_rom_msg.sv
`default_nettype none
// ============================================================================
//  Module   : char_rom_msg
//  Purpose  : Multi-message character ROM with typewriter reveal and optional
//             blink (compile with CHAR_ROM_BLINK_EN to enable blinking).
//  Revision : 1.0 - initial release
// ============================================================================
module char_rom_msg #(
    parameter int N_MSG        = 4,
    parameter int MSG_LEN      = 32,
    parameter int REVEAL_DIV   = 2,
    parameter int BLINK_PERIOD = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  msg_sel,
    input  logic        msg_load,
    input  logic        frame_tick,
    input  logic [11:0] char_xy,
    output logic [6:0]  char_code,
    output logic        busy,
    output logic        reveal_done
);

    localparam int c_rev_w   = $clog2(MSG_LEN + 1);
    localparam int c_div_w   = (REVEAL_DIV > 1) ? $clog2(REVEAL_DIV) : 1;

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_reveal = 2'd1;
    localparam logic [1:0] c_shown  = 2'd2;

    localparam logic [8*31-1:0] c_str0 = "GAMEOVER PRESS SPACE TO RESTART";
    localparam logic [8*20-1:0] c_str1 = "PRESS SPACE TO START";
    localparam logic [8*6-1:0]  c_str2 = "PAUSED";
    localparam logic [8*7-1:0]  c_str3 = "YOU WIN";
    localparam logic [6:0]      c_space = 7'h20;

    generate
        if (REVEAL_DIV < 1 || BLINK_PERIOD < 1 || N_MSG < 1 || N_MSG > 4) begin : g_param_check
            $error("char_rom_msg: illegal parameter value");
        end
    endgenerate

    function automatic logic [31:0] eff_len(input logic [1:0] m);
        logic [31:0] l;
        case (m)
            2'd0:    l = 32'd31;
            2'd1:    l = 32'd20;
            2'd2:    l = 32'd6;
            default: l = 32'd7;
        endcase
        return (l > 32'(MSG_LEN)) ? 32'(MSG_LEN) : l;
    endfunction

    logic [1:0]         r_state, w_state_n;
    logic [1:0]         r_msg, w_msg_n;
    logic [c_rev_w-1:0] r_rev_cnt, w_rev_n;
    logic [c_div_w-1:0] r_div, w_div_n;
    logic [6:0]         r_char_code;
    logic               r_busy, r_done;
    logic               w_load_ok;
    logic               w_visible;
    logic [31:0]        w_xy;
    logic [31:0]        w_limit;
    logic [6:0]         w_rom;
    logic [6:0]         w_char;

    assign w_load_ok = msg_load && (32'(msg_sel) < 32'(N_MSG));
    assign w_xy      = {20'd0, char_xy};

`ifdef CHAR_ROM_BLINK_EN
    localparam int c_blink_w = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

    logic [c_blink_w-1:0] r_blink_cnt, w_blink_n;
    logic                 r_vis, w_vis_n;

    // Blink phase only advances once the message is fully shown.
    always_comb begin
        w_blink_n = r_blink_cnt;
        w_vis_n   = r_vis;
        if (w_load_ok) begin
            w_blink_n = '0;
            w_vis_n   = 1'b1;
        end else if (r_state == c_shown && frame_tick) begin
            if (32'(r_blink_cnt) == 32'(BLINK_PERIOD - 1)) begin
                w_blink_n = '0;
                w_vis_n   = ~r_vis;
            end else begin
                w_blink_n = r_blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_vis       <= 1'b1;
        end else begin
            r_blink_cnt <= w_blink_n;
            r_vis       <= w_vis_n;
        end
    end

    assign w_visible = r_vis;
`else
    assign w_visible = 1'b1;
`endif

    // Next-state: a valid load always wins over a coincident frame tick.
    always_comb begin
        w_state_n = r_state;
        w_msg_n   = r_msg;
        w_rev_n   = r_rev_cnt;
        w_div_n   = r_div;
        if (w_load_ok) begin
            w_state_n = c_reveal;
            w_msg_n   = msg_sel;
            w_rev_n   = '0;
            w_div_n   = '0;
        end else if (r_state == c_reveal && frame_tick) begin
            if (32'(r_div) == 32'(REVEAL_DIV - 1)) begin
                w_div_n = '0;
                w_rev_n = r_rev_cnt + 1'b1;
                if (32'(r_rev_cnt) + 32'd1 >= eff_len(r_msg)) begin
                    w_state_n = c_shown;
                end
            end else begin
                w_div_n = r_div + 1'b1;
            end
        end
    end

    always_comb begin
        w_rom = c_space;
        case (r_msg)
            2'd0:    if (w_xy < 32'd31) w_rom = c_str0[8*(32'd30 - w_xy) +: 7];
            2'd1:    if (w_xy < 32'd20) w_rom = c_str1[8*(32'd19 - w_xy) +: 7];
            2'd2:    if (w_xy < 32'd6)  w_rom = c_str2[8*(32'd5 - w_xy) +: 7];
            default: if (w_xy < 32'd7)  w_rom = c_str3[8*(32'd6 - w_xy) +: 7];
        endcase
    end

    // Visible prefix length for the current state; IDLE shows nothing.
    always_comb begin
        w_limit = 32'd0;
        if (r_state == c_reveal) begin
            w_limit = 32'(r_rev_cnt);
        end else if (r_state == c_shown) begin
            w_limit = eff_len(r_msg);
        end
        w_char = c_space;
        if (w_visible && (w_xy < w_limit) && (w_xy < 32'(MSG_LEN)) &&
            (MSG_LEN > 64 || char_xy[11:6] == 6'd0)) begin
            w_char = w_rom;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_idle;
            r_msg       <= 2'd0;
            r_rev_cnt   <= '0;
            r_div       <= '0;
            r_char_code <= c_space;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_msg       <= w_msg_n;
            r_rev_cnt   <= w_rev_n;
            r_div       <= w_div_n;
            r_char_code <= w_char;
            r_busy      <= (w_state_n == c_reveal);
            r_done      <= (w_state_n == c_shown);
        end
    end

    assign char_code   = r_char_code;
    assign busy        = r_busy;
    assign reveal_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_char_rom_msg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_char_rom_msg
//  Purpose  : Directed self-checking bench for char_rom_msg (default build and
//             N_MSG = 2 instance sharing the same stimulus).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_char_rom_msg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  msg_sel = 2'd0;
    logic        msg_load = 1'b0;
    logic        frame_tick = 1'b0;
    logic [11:0] char_xy = 12'd0;
    logic [6:0]  char_code, char_code2;
    logic        busy, busy2, reveal_done, reveal_done2;

    int n_cmp = 0;
    int n_fail = 0;

    char_rom_msg dut (
        .clk(clk), .rst(rst), .msg_sel(msg_sel), .msg_load(msg_load),
        .frame_tick(frame_tick), .char_xy(char_xy), .char_code(char_code),
        .busy(busy), .reveal_done(reveal_done)
    );

    char_rom_msg #(.N_MSG(2)) dut2 (
        .clk(clk), .rst(rst), .msg_sel(msg_sel), .msg_load(msg_load),
        .frame_tick(frame_tick), .char_xy(char_xy), .char_code(char_code2),
        .busy(busy2), .reveal_done(reveal_done2)
    );

    always #5 clk = ~clk;

    task automatic load(input logic [1:0] sel, input logic with_tick);
        msg_sel    = sel;
        msg_load   = 1'b1;
        frame_tick = with_tick;
        @(negedge clk);
        msg_load   = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    endtask

    task automatic rd(input int idx, output logic [6:0] c1, output logic [6:0] c2);
        char_xy = 12'(idx);
        @(negedge clk);
        c1 = char_code;
        c2 = char_code2;
    endtask

    task automatic test_reset;
        logic [6:0] c, c2;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (char_code !== 7'h20 || busy !== 1'b0 || reveal_done !== 1'b0) begin
            $display("FAIL reset_outputs: code=%h busy=%b done=%b, want 20/0/0", char_code, busy, reveal_done);
            n_fail++;
        end
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            rd(i, c, c2);
            n_cmp++;
            if (c !== 7'h20) begin
                $display("FAIL reset_sweep[%0d]: got %h want 20", i, c);
                n_fail++;
            end
        end
    endtask

    task automatic test_reveal_m2;
        string exp = "PAUSED";
        logic [6:0] c, c2;
        load(2'd2, 1'b0);
        n_cmp++;
        if (busy !== 1'b1 || reveal_done !== 1'b0) begin
            $display("FAIL m2_busy_after_load: busy=%b done=%b want 1/0", busy, reveal_done);
            n_fail++;
        end
        ticks(6);
        for (int i = 0; i < 4; i++) begin
            rd(i, c, c2);
            n_cmp++;
            if (c !== ((i < 3) ? 7'(exp[i]) : 7'h20)) begin
                $display("FAIL m2_partial[%0d]: got %h want %h", i, c, (i < 3) ? 7'(exp[i]) : 7'h20);
                n_fail++;
            end
        end
        ticks(5);
        n_cmp++;
        if (busy !== 1'b1 || reveal_done !== 1'b0) begin
            $display("FAIL m2_tick11: busy=%b done=%b want 1/0", busy, reveal_done);
            n_fail++;
        end
        ticks(1);
        n_cmp++;
        if (busy !== 1'b0 || reveal_done !== 1'b1) begin
            $display("FAIL m2_tick12: busy=%b done=%b want 0/1", busy, reveal_done);
            n_fail++;
        end
        for (int i = 0; i < 7; i++) begin
            rd(i, c, c2);
            n_cmp++;
            if (c !== ((i < 6) ? 7'(exp[i]) : 7'h20)) begin
                $display("FAIL m2_full[%0d]: got %h want %h", i, c, (i < 6) ? 7'(exp[i]) : 7'h20);
                n_fail++;
            end
        end
    endtask

    task automatic test_m0_bounds;
        logic [6:0] c, c2;
        load(2'd0, 1'b0);
        ticks(61);
        n_cmp++;
        if (busy !== 1'b1) begin
            $display("FAIL m0_tick61_busy: got %b want 1", busy);
            n_fail++;
        end
        ticks(1);
        n_cmp++;
        if (reveal_done !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL m0_done: busy=%b done=%b want 0/1", busy, reveal_done);
            n_fail++;
        end
        rd(0, c, c2);
        n_cmp++;
        if (c !== 7'h47) begin $display("FAIL m0_idx0: got %h want 47", c); n_fail++; end
        rd(12'h01e, c, c2);
        n_cmp++;
        if (c !== 7'h54) begin $display("FAIL m0_idx1e: got %h want 54", c); n_fail++; end
        rd(12'h01f, c, c2);
        n_cmp++;
        if (c !== 7'h20) begin $display("FAIL m0_idx1f: got %h want 20", c); n_fail++; end
        rd(12'h040, c, c2);
        n_cmp++;
        if (c !== 7'h20) begin $display("FAIL m0_idx40: got %h want 20", c); n_fail++; end
        rd(12'h809, c, c2);
        n_cmp++;
        if (c !== 7'h20) begin $display("FAIL m0_idx809: got %h want 20", c); n_fail++; end
    endtask

    task automatic test_load_during_reveal;
        string exp = "YOU WIN";
        logic [6:0] c, c2;
        load(2'd0, 1'b0);
        ticks(10);
        load(2'd3, 1'b1);
        for (int i = 0; i < 8; i++) begin
            rd(i, c, c2);
            n_cmp++;
            if (c !== 7'h20) begin $display("FAIL restart_blank[%0d]: got %h want 20", i, c); n_fail++; end
        end
        ticks(13);
        n_cmp++;
        if (busy !== 1'b1 || reveal_done !== 1'b0) begin
            $display("FAIL restart_tick13: busy=%b done=%b want 1/0", busy, reveal_done);
            n_fail++;
        end
        ticks(1);
        n_cmp++;
        if (reveal_done !== 1'b1) begin $display("FAIL restart_done: got %b want 1", reveal_done); n_fail++; end
        for (int i = 0; i < 7; i++) begin
            rd(i, c, c2);
            n_cmp++;
            if (c !== 7'(exp[i])) begin $display("FAIL m3_full[%0d]: got %h want %h", i, c, 7'(exp[i])); n_fail++; end
        end
        load(2'd3, 1'b0);
        rd(0, c, c2);
        n_cmp++;
        if (c !== 7'h20 || busy !== 1'b1 || reveal_done !== 1'b0) begin
            $display("FAIL reload_same: code=%h busy=%b done=%b want 20/1/0", c, busy, reveal_done);
            n_fail++;
        end
    endtask

    task automatic test_ignored_sel;
        string exp = "PRESS SPACE TO START";
        logic [6:0] c, c2;
        load(2'd1, 1'b0);
        ticks(40);
        load(2'd3, 1'b0);
        load(2'd2, 1'b1);
        n_cmp++;
        if (reveal_done2 !== 1'b1 || busy2 !== 1'b0) begin
            $display("FAIL ignored_sel_state: busy=%b done=%b want 0/1", busy2, reveal_done2);
            n_fail++;
        end
        for (int i = 0; i < 21; i++) begin
            rd(i, c, c2);
            n_cmp++;
            if (c2 !== ((i < 20) ? 7'(exp[i]) : 7'h20)) begin
                $display("FAIL ignored_sel[%0d]: got %h want %h", i, c2, (i < 20) ? 7'(exp[i]) : 7'h20);
                n_fail++;
            end
        end
    endtask

    task automatic test_blink;
        logic [6:0] c, c2, want_off;
`ifdef CHAR_ROM_BLINK_EN
        want_off = 7'h20;
`else
        want_off = 7'h50;
`endif
        load(2'd2, 1'b0);
        ticks(12);
        ticks(29);
        rd(0, c, c2);
        n_cmp++;
        if (c !== 7'h50) begin $display("FAIL blink_t29: got %h want 50", c); n_fail++; end
        ticks(1);
        rd(0, c, c2);
        n_cmp++;
        if (c !== want_off) begin $display("FAIL blink_t30: got %h want %h", c, want_off); n_fail++; end
        ticks(29);
        rd(0, c, c2);
        n_cmp++;
        if (c !== want_off || reveal_done !== 1'b1) begin
            $display("FAIL blink_t59: code=%h done=%b want %h/1", c, reveal_done, want_off);
            n_fail++;
        end
        ticks(1);
        rd(0, c, c2);
        n_cmp++;
        if (c !== 7'h50) begin $display("FAIL blink_t60: got %h want 50", c); n_fail++; end
    endtask

    task automatic test_async_reset;
        load(2'd2, 1'b0);
        ticks(4);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || reveal_done !== 1'b0 || char_code !== 7'h20) begin
            $display("FAIL async_reset: busy=%b done=%b code=%h want 0/0/20", busy, reveal_done, char_code);
            n_fail++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reveal_m2();
        test_m0_bounds();
        test_load_during_reveal();
        test_ignored_sel();
        test_blink();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
